// File: rtl/mef_fertirrigacao_zonas_pkg.sv
// Shared types and default constants for the zoned fertigation sequencer.
package rega_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ENCHE   = 3'd1,
    MISTURA = 3'd2,
    REGA    = 3'd3,
    LIMPA   = 3'd4
  } estado_t;

  localparam int ZONES_DEF     = 4;
  localparam int LVL_W_DEF     = 3;
  localparam int LVL_FULL_DEF  = 7;
  localparam int LVL_EMPTY_DEF = 1;
  localparam int MIX_CYC_DEF   = 8;
  localparam int ZONE_CYC_DEF  = 16;
  localparam int CLEAN_CYC_DEF = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mef_fertirrigacao_zonas_if.sv
// Request/sensor inputs and valve-driver outputs of the fertigation sequencer.
interface mef_fertirrigacao_zonas_if #(
  parameter int ZONES = 4,
  parameter int LVL_W = 3
);
  logic             adub;
  logic [ZONES-1:0] asp;
  logic [LVL_W-1:0] nivel;
  logic             ve;
  logic             mist;
  logic             limp;
  logic [ZONES-1:0] zona_ve;
  logic             busy;
  logic             fim;

  modport master (
    output adub, asp, nivel,
    input  ve, mist, limp, zona_ve, busy, fim
  );

  modport slave (
    input  adub, asp, nivel,
    output ve, mist, limp, zona_ve, busy, fim
  );
endinterface

// File: rtl/rr_seletor_zona.sv
// Combinational round-robin picker: first set bit of pend at or above rr_ptr, wrapping.
module rr_seletor_zona #(
  parameter int ZONES = 4,
  parameter int IW    = $clog2(ZONES)
) (
  input  logic [ZONES-1:0] pend,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    cur,
  output logic             valid
);

  // Scan offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    cur   = {IW{1'b0}};
    valid = 1'b0;
    sum   = {(IW+1){1'b0}};
    idx   = {IW{1'b0}};
    for (int i = ZONES-1; i >= 0; i--) begin
      sum   = {1'b0, rr_ptr} + (IW+1)'(i);
      idx   = (sum >= (IW+1)'(ZONES)) ? IW'(sum - (IW+1)'(ZONES)) : IW'(sum);
      cur   = pend[idx] ? idx : cur;
      valid = valid | pend[idx];
    end
  end

endmodule

// File: rtl/mef_fertirrigacao_zonas.sv
// Fertigation sequencer: fill, optional mix, round-robin zone irrigation, optional cleaning.
module mef_fertirrigacao_zonas
  import rega_pkg::*;
#(
  parameter int ZONES     = ZONES_DEF,
  parameter int LVL_W     = LVL_W_DEF,
  parameter int LVL_FULL  = LVL_FULL_DEF,
  parameter int LVL_EMPTY = LVL_EMPTY_DEF,
  parameter int MIX_CYC   = MIX_CYC_DEF,
  parameter int ZONE_CYC  = ZONE_CYC_DEF,
  parameter int CLEAN_CYC = CLEAN_CYC_DEF
) (
  input logic clk,
  input logic reset,
  mef_fertirrigacao_zonas_if.slave bus
);

  localparam int IW = $clog2(ZONES);
  localparam int CW = $clog2(max3(MIX_CYC, ZONE_CYC, CLEAN_CYC)) + 1;

  estado_t          state_r, state_nx_s;
  logic [ZONES-1:0] pend_r, pend_nx_s;
  logic             fert_r, fert_nx_s;
  logic [IW-1:0]    rr_ptr_r, rr_ptr_nx_s;
  logic [CW-1:0]    zcnt_r, zcnt_nx_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s;
  logic             end_s;
  logic [IW-1:0]    cur_s;
  logic             valid_s;

  logic             ve_r, mist_r, limp_r, busy_r, fim_r;
  logic [ZONES-1:0] zona_ve_r;

  rr_seletor_zona #(.ZONES(ZONES), .IW(IW)) u_sel (
    .pend   (pend_r),
    .rr_ptr (rr_ptr_r),
    .cur    (cur_s),
    .valid  (valid_s)
  );

  // Next-state and session bookkeeping
  always_comb begin
    state_nx_s  = state_r;
    pend_nx_s   = pend_r;
    fert_nx_s   = fert_r;
    rr_ptr_nx_s = rr_ptr_r;
    zcnt_nx_s   = zcnt_r;
    cnt_nx_s    = cnt_r;
    end_s       = 1'b0;
    case (state_r)
      OCIOSO: begin
        if (bus.asp != {ZONES{1'b0}}) begin
          pend_nx_s = bus.asp;
          fert_nx_s = bus.adub;
          cnt_nx_s  = {CW{1'b0}};
          if (bus.nivel < LVL_W'(LVL_FULL)) begin
            state_nx_s = ENCHE;
          end else begin
            state_nx_s = bus.adub ? MISTURA : REGA;
          end
        end else begin
          state_nx_s = OCIOSO;
        end
      end
      ENCHE: begin
        if (bus.nivel >= LVL_W'(LVL_FULL)) begin
          cnt_nx_s   = {CW{1'b0}};
          state_nx_s = fert_r ? MISTURA : REGA;
        end else begin
          state_nx_s = ENCHE;
        end
      end
      MISTURA: begin
        if (cnt_r == CW'(MIX_CYC - 1)) begin
          cnt_nx_s   = {CW{1'b0}};
          state_nx_s = REGA;
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      REGA: begin
        // Finish wins over an empty tank; an interrupted zone keeps its elapsed time
        if (valid_s && (!bus.asp[cur_s] || zcnt_r == CW'(ZONE_CYC - 1))) begin
          pend_nx_s[cur_s] = 1'b0;
          rr_ptr_nx_s      = (cur_s == IW'(ZONES - 1)) ? {IW{1'b0}} : cur_s + IW'(1);
          zcnt_nx_s        = {CW{1'b0}};
        end else begin
          zcnt_nx_s = zcnt_r + CW'(1);
        end
        if (pend_nx_s == {ZONES{1'b0}}) begin
          cnt_nx_s   = {CW{1'b0}};
          state_nx_s = fert_r ? LIMPA : OCIOSO;
          end_s      = ~fert_r;
        end else if (bus.nivel <= LVL_W'(LVL_EMPTY)) begin
          state_nx_s = ENCHE;
        end else begin
          state_nx_s = REGA;
        end
      end
      LIMPA: begin
        if (cnt_r == CW'(CLEAN_CYC - 1)) begin
          state_nx_s = OCIOSO;
          end_s      = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nx_s = OCIOSO;
      end
    endcase
  end

  // State and session registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= OCIOSO;
      pend_r   <= {ZONES{1'b0}};
      fert_r   <= 1'b0;
      rr_ptr_r <= {IW{1'b0}};
      zcnt_r   <= {CW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      state_r  <= state_nx_s;
      pend_r   <= pend_nx_s;
      fert_r   <= fert_nx_s;
      rr_ptr_r <= rr_ptr_nx_s;
      zcnt_r   <= zcnt_nx_s;
      cnt_r    <= cnt_nx_s;
    end
  end

  // Registered Moore outputs decoded from the current state and zone
  always_ff @(posedge clk) begin
    if (reset) begin
      ve_r      <= 1'b0;
      mist_r    <= 1'b0;
      limp_r    <= 1'b0;
      zona_ve_r <= {ZONES{1'b0}};
      busy_r    <= 1'b0;
      fim_r     <= 1'b0;
    end else begin
      ve_r      <= (state_r == ENCHE);
      mist_r    <= (state_r == MISTURA);
      limp_r    <= (state_r == LIMPA);
      zona_ve_r <= (state_r == REGA && valid_s) ?
                   ({{(ZONES-1){1'b0}}, 1'b1} << cur_s) : {ZONES{1'b0}};
      busy_r    <= (state_r != OCIOSO);
      fim_r     <= end_s;
    end
  end

  assign bus.ve      = ve_r;
  assign bus.mist    = mist_r;
  assign bus.limp    = limp_r;
  assign bus.zona_ve = zona_ve_r;
  assign bus.busy    = busy_r;
  assign bus.fim     = fim_r;

endmodule
